// File: rtl/seg_page_scheduler_pkg.sv
// Shared constants, FSM state type and page-selection helper for the 7-seg page scheduler.
package seg_page_scheduler_pkg;

    localparam int unsigned SEG_DIGIT_W = 7;
    localparam int unsigned SEG_WORD_W  = 4 * SEG_DIGIT_W;
    localparam int unsigned NUM_PAGES   = 3;

    localparam logic [SEG_WORD_W-1:0] SEG_BLANK = 28'hFFFFFFF;
    localparam logic [1:0]            PAGE_NONE = 2'd3;

    typedef enum logic [1:0] {
        StBlank = 2'd0,
        StShow  = 2'd1,
        StAlert = 2'd2
    } state_e;

    // First valid page strictly after cur (wrapping), cur itself last; PAGE_NONE if none valid.
    function automatic logic [1:0] next_valid(input logic [NUM_PAGES-1:0] valid,
                                              input logic [1:0] cur);
        logic [1:0] idx;
        logic [1:0] res;
        res = PAGE_NONE;
        for (int k = NUM_PAGES; k >= 1; k--) begin
            idx = 2'((int'(cur) + k) % NUM_PAGES);
            if (valid[idx]) res = idx;
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_page_scheduler_req_latch.sv
// One requester slot: segment word register, valid flag and alternating ack pulse.
module seg_page_scheduler_req_latch
    import seg_page_scheduler_pkg::*;
(
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  req_in,
    input  logic                  clr_in,
    input  logic [SEG_WORD_W-1:0] data_in,
    output logic                  ack_out,
    output logic                  valid_out,
    output logic [SEG_WORD_W-1:0] word_out
);

    logic                  ack_q;
    logic                  valid_q;
    logic [SEG_WORD_W-1:0] word_q;
    logic                  accept;

    // A held request is accepted only when the previous cycle did not ack it.
    assign accept = req_in & ~ack_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            word_q  <= SEG_BLANK;
        end else begin
            ack_q <= accept;
            if (accept) begin
                word_q  <= data_in;
                valid_q <= 1'b1;
            end else if (clr_in) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign ack_out   = ack_q;
    assign valid_out = valid_q;
    assign word_out  = word_q;

endmodule

// File: rtl/seg_page_scheduler.sv
// Rotates up to three latched 7-seg pages on a dwell timer; an alert word pre-empts rotation.
module seg_page_scheduler
    import seg_page_scheduler_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 100_000_000,
    parameter int unsigned ALERT_CYCLES = 300_000_000,
    parameter int unsigned CNT_W        = 29
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [2:0]            req_in,
    input  logic [83:0]           data_in,
    output logic [2:0]            ack_out,
    input  logic [2:0]            clr_in,
    input  logic                  alert_req_in,
    input  logic [SEG_WORD_W-1:0] alert_data_in,
    output logic                  alert_ack_out,
    output logic [SEG_WORD_W-1:0] number_out,
    output logic [1:0]            page_out,
    output logic                  alert_active_out
);

    logic [NUM_PAGES-1:0]  valid;
    logic [SEG_WORD_W-1:0] page_word [NUM_PAGES];
    logic                  alert_valid;
    logic [SEG_WORD_W-1:0] alert_word;

    for (genvar i = 0; i < NUM_PAGES; i++) begin : g_page
        seg_page_scheduler_req_latch u_page (
            .clk_in    (clk_in),
            .rst_n_in  (rst_n_in),
            .req_in    (req_in[i]),
            .clr_in    (clr_in[i]),
            .data_in   (data_in[SEG_WORD_W*i +: SEG_WORD_W]),
            .ack_out   (ack_out[i]),
            .valid_out (valid[i]),
            .word_out  (page_word[i])
        );
    end

    seg_page_scheduler_req_latch u_alert (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .req_in    (alert_req_in),
        .clr_in    (1'b0),
        .data_in   (alert_data_in),
        .ack_out   (alert_ack_out),
        .valid_out (alert_valid),
        .word_out  (alert_word)
    );

    state_e                state_q, state_d;
    logic [1:0]            cur_q, cur_d;
    logic [CNT_W-1:0]      timer_q, timer_d;
    logic [SEG_WORD_W-1:0] number_q, number_d;
    logic [1:0]            page_q, page_d;
    logic                  active_q, active_d;
    logic [1:0]            nxt;
    logic [1:0]            resume;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        timer_d = timer_q;
        nxt     = next_valid(valid, cur_q);
        resume  = valid[cur_q] ? cur_q : nxt;

        // The alert ack pulse marks an accepted alert word and overrides any other transition.
        if (alert_ack_out) begin
            state_d = StAlert;
            timer_d = '0;
        end else begin
            unique case (state_q)
                StBlank: begin
                    if (|valid) begin
                        state_d = StShow;
                        cur_d   = next_valid(valid, 2'd2);
                        timer_d = '0;
                    end
                end
                StShow: begin
                    if (!valid[cur_q]) begin
                        timer_d = '0;
                        if (nxt == PAGE_NONE) state_d = StBlank;
                        else                  cur_d   = nxt;
                    end else if (timer_q == CNT_W'(DWELL_CYCLES - 1)) begin
                        timer_d = '0;
                        cur_d   = nxt;
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
                StAlert: begin
                    if (timer_q == CNT_W'(ALERT_CYCLES - 1)) begin
                        timer_d = '0;
                        if (resume == PAGE_NONE) begin
                            state_d = StBlank;
                        end else begin
                            state_d = StShow;
                            cur_d   = resume;
                        end
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
                default: state_d = StBlank;
            endcase
        end

        number_d = SEG_BLANK;
        page_d   = PAGE_NONE;
        active_d = (state_d == StAlert);
        if (state_d == StShow) begin
            number_d = page_word[cur_d];
            page_d   = cur_d;
        end else if (state_d == StAlert && alert_valid) begin
            number_d = alert_word;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= StBlank;
            cur_q    <= 2'd0;
            timer_q  <= '0;
            number_q <= SEG_BLANK;
            page_q   <= PAGE_NONE;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            timer_q  <= timer_d;
            number_q <= number_d;
            page_q   <= page_d;
            active_q <= active_d;
        end
    end

    assign number_out       = number_q;
    assign page_out         = page_q;
    assign alert_active_out = active_q;

endmodule

// File: tb/tb_seg_page_scheduler.sv
// Self-checking bench for seg_page_scheduler: directed table, corner sequences, random vs model.
module tb_seg_page_scheduler;

    localparam int DW = 4;
    localparam int AW = 3;
    localparam logic [27:0] BLANK = 28'hFFFFFFF;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [2:0]  req_in;
    logic [83:0] data_in;
    logic [2:0]  ack_out;
    logic [2:0]  clr_in;
    logic        alert_req_in;
    logic [27:0] alert_data_in;
    logic        alert_ack_out;
    logic [27:0] number_out;
    logic [1:0]  page_out;
    logic        alert_active_out;

    always #5 clk_in = ~clk_in;

    seg_page_scheduler #(
        .DWELL_CYCLES (DW),
        .ALERT_CYCLES (AW),
        .CNT_W        (4)
    ) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .req_in           (req_in),
        .data_in          (data_in),
        .ack_out          (ack_out),
        .clr_in           (clr_in),
        .alert_req_in     (alert_req_in),
        .alert_data_in    (alert_data_in),
        .alert_ack_out    (alert_ack_out),
        .number_out       (number_out),
        .page_out         (page_out),
        .alert_active_out (alert_active_out)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: mode 0=blank, 1=show, 2=alert; age counts cycles spent in the current view.
    bit          m_valid [3];
    logic [27:0] m_word  [3];
    bit          m_ack   [3];
    logic [27:0] m_aword;
    bit          m_aack;
    int          m_mode;
    int          m_cur;
    int          m_age;
    logic [27:0] e_num;
    int          e_page;
    bit          e_alert;

    function automatic int pick_after(int c);
        int r = -1;
        for (int k = 3; k >= 1; k--) if (m_valid[(c + k) % 3]) r = (c + k) % 3;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_valid[i] = 0; m_word[i] = BLANK; m_ack[i] = 0;
        end
        m_aword = BLANK; m_aack = 0;
        m_mode = 0; m_cur = 0; m_age = 0;
        e_num = BLANK; e_page = 3; e_alert = 0;
    endtask

    task automatic model_step();
        int p;
        if (m_aack) begin
            m_mode = 2; m_age = 0;
        end else if (m_mode == 0) begin
            p = pick_after(2);
            if (p >= 0) begin m_mode = 1; m_cur = p; m_age = 0; end
        end else if (m_mode == 1) begin
            if (!m_valid[m_cur]) begin
                p = pick_after(m_cur); m_age = 0;
                if (p < 0) m_mode = 0; else m_cur = p;
            end else if (m_age + 1 == DW) begin
                m_age = 0; m_cur = pick_after(m_cur);
            end else m_age++;
        end else begin
            if (m_age + 1 == AW) begin
                m_age = 0;
                p = m_valid[m_cur] ? m_cur : pick_after(m_cur);
                if (p < 0) m_mode = 0; else begin m_mode = 1; m_cur = p; end
            end else m_age++;
        end
        e_num   = (m_mode == 1) ? m_word[m_cur] : (m_mode == 2) ? m_aword : BLANK;
        e_page  = (m_mode == 1) ? m_cur : 3;
        e_alert = (m_mode == 2);
        for (int i = 0; i < 3; i++) begin
            if (req_in[i] && !m_ack[i]) begin
                m_word[i] = data_in[28*i +: 28]; m_valid[i] = 1; m_ack[i] = 1;
            end else begin
                m_ack[i] = 0;
                if (clr_in[i]) m_valid[i] = 0;
            end
        end
        if (alert_req_in && !m_aack) begin
            m_aword = alert_data_in; m_aack = 1;
        end else m_aack = 0;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_step();
        #1;
        check("number_out", 32'(number_out), 32'(e_num));
        check("page_out", 32'(page_out), 32'(e_page));
        check("alert_active_out", 32'(alert_active_out), 32'(e_alert));
        check("ack_out", 32'(ack_out), {29'd0, m_ack[2], m_ack[1], m_ack[0]});
        check("alert_ack_out", 32'(alert_ack_out), 32'(m_aack));
    endtask

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  clr;
        logic [2:0]  ack;
        logic [1:0]  page;
        logic [27:0] num;
    } vec_t;

    vec_t tbl [14];
    int   pulses;

    initial begin
        tbl[0]  = '{3'b001, 3'b000, 3'b001, 2'd3, BLANK};
        tbl[1]  = '{3'b000, 3'b000, 3'b000, 2'd0, 28'h0000001};
        tbl[2]  = '{3'b000, 3'b000, 3'b000, 2'd0, 28'h0000001};
        tbl[3]  = '{3'b000, 3'b000, 3'b000, 2'd0, 28'h0000001};
        tbl[4]  = '{3'b000, 3'b000, 3'b000, 2'd0, 28'h0000001};
        tbl[5]  = '{3'b100, 3'b000, 3'b100, 2'd0, 28'h0000001};
        tbl[6]  = '{3'b000, 3'b000, 3'b000, 2'd0, 28'h0000001};
        tbl[7]  = '{3'b000, 3'b000, 3'b000, 2'd0, 28'h0000001};
        tbl[8]  = '{3'b000, 3'b000, 3'b000, 2'd0, 28'h0000001};
        tbl[9]  = '{3'b000, 3'b000, 3'b000, 2'd2, 28'h0000002};
        tbl[10] = '{3'b000, 3'b000, 3'b000, 2'd2, 28'h0000002};
        tbl[11] = '{3'b000, 3'b000, 3'b000, 2'd2, 28'h0000002};
        tbl[12] = '{3'b000, 3'b000, 3'b000, 2'd2, 28'h0000002};
        tbl[13] = '{3'b000, 3'b000, 3'b000, 2'd0, 28'h0000001};

        rst_n_in = 1'b0;
        req_in = '0; clr_in = '0; alert_req_in = 1'b0; alert_data_in = '0;
        data_in = {28'h0000002, 28'h0000003, 28'h0000001};
        model_reset();
        #12;
        check("reset_number", 32'(number_out), 32'(BLANK));
        check("reset_page", 32'(page_out), 32'd3);
        check("reset_ack", 32'({alert_ack_out, ack_out}), 32'd0);
        check("reset_alert_active", 32'(alert_active_out), 32'd0);
        rst_n_in = 1'b1;

        // Single page then rotation 0,0,0,0,2,2,2,2,0 skipping invalid page 1
        for (int i = 0; i < 14; i++) begin
            req_in = tbl[i].req; clr_in = tbl[i].clr;
            tick();
            check("tbl_ack", 32'(ack_out), 32'(tbl[i].ack));
            check("tbl_page", 32'(page_out), 32'(tbl[i].page));
            check("tbl_number", 32'(number_out), 32'(tbl[i].num));
        end
        req_in = '0;

        // Clearing the shown page, then the last page
        repeat (4) tick();
        check("show_page2", 32'(page_out), 32'd2);
        clr_in = 3'b100; tick(); clr_in = '0; tick();
        check("clr2_to_page0", 32'(page_out), 32'd0);
        clr_in = 3'b001; tick(); clr_in = '0; tick();
        check("clr0_blank_number", 32'(number_out), 32'(BLANK));
        check("clr0_blank_page", 32'(page_out), 32'd3);

        // Alert pre-emption and resume
        req_in = 3'b001; tick(); req_in = '0; tick();
        check("resume_src_page0", 32'(page_out), 32'd0);
        alert_req_in = 1'b1; alert_data_in = 28'h1234567; tick();
        check("alert_ack", 32'(alert_ack_out), 32'd1);
        alert_req_in = 1'b0;
        for (int k = 0; k < AW; k++) begin
            tick();
            check("alert_active", 32'(alert_active_out), 32'd1);
            check("alert_number", 32'(number_out), 32'h1234567);
        end
        tick();
        check("alert_exit_active", 32'(alert_active_out), 32'd0);
        check("alert_exit_page", 32'(page_out), 32'd0);

        // Re-accept during alert restarts the hold
        alert_req_in = 1'b1; tick(); alert_req_in = 1'b0;
        tick(); tick();
        alert_req_in = 1'b1; alert_data_in = 28'h7654321; tick(); alert_req_in = 1'b0;
        for (int k = 0; k < AW; k++) begin
            tick();
            check("realert_active", 32'(alert_active_out), 32'd1);
            check("realert_number", 32'(number_out), 32'h7654321);
        end
        tick();
        check("realert_exit", 32'(alert_active_out), 32'd0);

        // Request beats same-cycle clear; held request acks every other cycle
        req_in = 3'b010; clr_in = 3'b010; tick();
        check("req_beats_clr_ack", 32'(ack_out), 32'b010);
        req_in = '0; clr_in = '0; tick();
        pulses = 0;
        req_in = 3'b010;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (ack_out[1]) pulses++;
        end
        req_in = '0;
        check("held_req_pulses", 32'(pulses), 32'd3);

        // Asynchronous reset mid-rotation
        repeat (3) tick();
        rst_n_in = 1'b0;
        #1;
        check("midreset_number", 32'(number_out), 32'(BLANK));
        check("midreset_page", 32'(page_out), 32'd3);
        check("midreset_ack", 32'(ack_out), 32'd0);
        model_reset();
        #2 rst_n_in = 1'b1;

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 3; i++) begin
                req_in[i] = ($urandom_range(0, 7) == 0);
                clr_in[i] = ($urandom_range(0, 11) == 0);
                data_in[28*i +: 28] = 28'($urandom);
            end
            alert_req_in  = ($urandom_range(0, 29) == 0);
            alert_data_in = 28'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
